// File: rtl/core_pkg.sv
// core_pkg: shared RV32 core constants
package core_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] RV_NOP = 32'h0000_0013;
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one payload register with valid flag; clear beats load
module pipe_slot
  import core_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic             valid,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
endmodule

// File: rtl/pipeline_stage_hs.sv
// pipeline_stage_hs: handshaked stage register with optional skid entry and bubble output
module pipeline_stage_hs
  import core_pkg::*;
#(
  parameter int          WIDTH      = XLEN,
  parameter int          SKID       = 1,
  parameter logic [31:0] BUBBLE_VAL = RV_NOP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);
  localparam logic [WIDTH-1:0] BUB = WIDTH'(BUBBLE_VAL);
  logic             main_valid, skid_valid, main_load, main_clear, in_fire, out_fire;
  logic [WIDTH-1:0] main_data, skid_data, main_d;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_valid & out_ready;
  pipe_slot #(.WIDTH(WIDTH)) u_main (
    .clk(clk), .reset(reset), .load(main_load), .clear(main_clear),
    .d(main_d), .valid(main_valid), .q(main_data)
  );
  generate
    if (SKID != 0) begin : g_skid
      logic skid_load, skid_clear;
      // main refills from skid first so the oldest beat always sits in main
      always_comb begin
        main_d     = skid_valid ? skid_data : in_data;
        main_load  = skid_valid ? out_fire : in_fire & (~main_valid | out_fire);
        main_clear = flush | (out_fire & ~skid_valid & ~in_fire);
        skid_load  = in_fire & main_valid & ~out_fire;
        skid_clear = flush | (out_fire & skid_valid);
      end
      assign in_ready = ~skid_valid;
      pipe_slot #(.WIDTH(WIDTH)) u_skid (
        .clk(clk), .reset(reset), .load(skid_load), .clear(skid_clear),
        .d(in_data), .valid(skid_valid), .q(skid_data)
      );
    end else begin : g_single
      always_comb begin
        main_d     = in_data;
        main_load  = in_fire;
        main_clear = flush | (out_fire & ~in_fire);
      end
      assign in_ready   = ~main_valid | out_ready;
      assign skid_valid = 1'b0;
      assign skid_data  = '0;
    end
  endgenerate
  assign out_valid = main_valid;
  assign out_data  = main_valid ? main_data : BUB;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};
endmodule

// File: tb/tb_pipeline_stage_hs.sv
// tb_pipeline_stage_hs: scoreboard bench for skid and single-entry stage variants
module tb_pipeline_stage_hs;
  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready, in_ready, out_valid;
  logic [31:0] in_data, out_data;
  logic [1:0]  occupancy;
  logic        f0, v0, rdy0, in_ready0, ov0, e0;
  logic [31:0] dat0, od0;
  logic [1:0]  occ0;
  logic [31:0] q1[$];
  logic [31:0] m0[$];
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  pipeline_stage_hs #(.WIDTH(32), .SKID(1), .BUBBLE_VAL(32'h13)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );
  pipeline_stage_hs #(.WIDTH(32), .SKID(0), .BUBBLE_VAL(32'h13)) dut0 (
    .clk(clk), .reset(reset), .flush(f0), .in_valid(v0), .in_ready(in_ready0),
    .in_data(dat0), .out_valid(ov0), .out_ready(rdy0), .out_data(od0),
    .occupancy(occ0)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  // skid-variant scoreboard: every delivered beat must match the oldest expected beat
  always @(negedge clk)
    if (!reset) begin
      if (out_valid && out_ready) begin
        if (q1.size() == 0) begin
          total++;
          bad++;
          $display("FAIL d1_unexpected got=%h expected=none", out_data);
        end else chk("d1_data", out_data, q1.pop_front());
      end else if (!out_valid) chk("d1_bubble", out_data, 32'h13);
    end
  // single-entry variant: reference queue model evaluated every cycle
  always @(negedge clk)
    if (reset) m0.delete();
    else begin
      e0 = (m0.size() == 0) || rdy0;
      chk("d0_in_ready", {31'b0, in_ready0}, {31'b0, e0});
      chk("d0_out_valid", {31'b0, ov0}, {31'b0, m0.size() != 0});
      chk("d0_occ", {30'b0, occ0}, 32'(m0.size()));
      chk("d0_data", od0, m0.size() == 0 ? 32'h13 : m0[0]);
      if (m0.size() != 0 && rdy0) void'(m0.pop_front());
      if (f0) m0.delete();
      else if (v0 && e0) m0.push_back(dat0);
    end
  initial begin
    reset = 1; flush = 0; in_valid = 0; in_data = 0; out_ready = 0;
    f0 = 0; v0 = 0; dat0 = 0; rdy0 = 0;
    cyc(); cyc();
    reset = 0;
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'h13);
    chk("rst_occ", {30'b0, occupancy}, 32'd0);
    // streaming
    out_ready = 1;
    in_valid = 1; in_data = 1; q1.push_back(1);
    cyc();
    for (int k = 2; k <= 4; k++) begin
      in_data = k; q1.push_back(k);
      chk("stream_valid", {31'b0, out_valid}, 32'd1);
      cyc();
    end
    in_valid = 0;
    chk("stream_last_valid", {31'b0, out_valid}, 32'd1);
    chk("stream_last_data", out_data, 32'd4);
    cyc();
    chk("stream_done", {31'b0, out_valid}, 32'd0);
    // backpressure into skid
    out_ready = 0;
    in_valid = 1; in_data = 32'hA; q1.push_back(32'hA);
    cyc();
    in_data = 32'hB; q1.push_back(32'hB);
    cyc();
    in_valid = 0;
    chk("bp_occ", {30'b0, occupancy}, 32'd2);
    chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    chk("bp_data", out_data, 32'hA);
    cyc();
    chk("bp_hold", out_data, 32'hA);
    chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
    out_ready = 1;
    cyc();
    chk("bp_second", out_data, 32'hB);
    chk("bp_occ1", {30'b0, occupancy}, 32'd1);
    chk("bp_ready_back", {31'b0, in_ready}, 32'd1);
    cyc();
    chk("bp_empty", {30'b0, occupancy}, 32'd0);
    // flush with full stage; C must never surface
    out_ready = 0;
    in_valid = 1; in_data = 32'hE;
    cyc();
    in_data = 32'hF;
    cyc();
    chk("fl_occ_pre", {30'b0, occupancy}, 32'd2);
    flush = 1; in_data = 32'hC;
    cyc();
    flush = 0; in_valid = 0;
    chk("fl_valid", {31'b0, out_valid}, 32'd0);
    chk("fl_data", out_data, 32'h13);
    chk("fl_occ", {30'b0, occupancy}, 32'd0);
    chk("fl_in_ready", {31'b0, in_ready}, 32'd1);
    // flush discards an accepted in-fire
    in_valid = 1; in_data = 32'h6;
    cyc();
    flush = 1; in_data = 32'hC;
    cyc();
    flush = 0; in_valid = 0;
    chk("fl2_occ", {30'b0, occupancy}, 32'd0);
    cyc();
    chk("fl2_still_empty", {31'b0, out_valid}, 32'd0);
    // simultaneous out-fire and in-fire with one beat held
    in_valid = 1; in_data = 32'h77; q1.push_back(32'h77);
    cyc();
    out_ready = 1; in_data = 32'hD; q1.push_back(32'hD);
    cyc();
    in_valid = 0;
    chk("sim_valid", {31'b0, out_valid}, 32'd1);
    chk("sim_data", out_data, 32'hD);
    chk("sim_occ", {30'b0, occupancy}, 32'd1);
    cyc();
    chk("sim_drained", {30'b0, occupancy}, 32'd0);
    // reset with two beats held
    out_ready = 0;
    in_valid = 1; in_data = 32'h11;
    cyc();
    in_data = 32'h22;
    cyc();
    in_valid = 0;
    chk("rm_occ_pre", {30'b0, occupancy}, 32'd2);
    #2 reset = 1;
    #1;
    chk("rm_valid", {31'b0, out_valid}, 32'd0);
    chk("rm_data", out_data, 32'h13);
    chk("rm_occ", {30'b0, occupancy}, 32'd0);
    cyc();
    reset = 0;
    cyc();
    chk("rm_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rm_still_empty", {31'b0, out_valid}, 32'd0);
    // single-entry variant: combinational in_ready, then random stress
    v0 = 1; dat0 = 32'h55; rdy0 = 0;
    cyc();
    #1;
    chk("d0_full_ready", {31'b0, in_ready0}, 32'd0);
    rdy0 = 1;
    #1;
    chk("d0_ready_comb", {31'b0, in_ready0}, 32'd1);
    for (int i = 0; i < 10000; i++) begin
      cyc();
      v0 = 1'($urandom_range(0, 1));
      dat0 = $urandom;
      rdy0 = 1'($urandom_range(0, 1));
      f0 = ($urandom_range(0, 31) == 0);
    end
    cyc();
    v0 = 0; rdy0 = 1; f0 = 0;
    cyc(); cyc(); cyc();
    chk("d0_drain", 32'(m0.size()), 32'd0);
    chk("d1_queue_empty", 32'(q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
